// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller driving a shared BCD-to-7-segment decoder.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int IDXW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNTW   = (CNTMAX > 1) ? $clog2(CNTMAX) : 1;

    localparam logic [CNTW-1:0] ON_LAST  = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] GAP_LAST = CNTW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_ON, S_GAP} state_t;

    state_t                  state;
    logic [IDXW-1:0]         idx;
    logic [CNTW-1:0]         cnt;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic [4*NUM_DIGITS-1:0] act_reg;

    logic                    go_on;
    logic [IDXW-1:0]         tgt_idx;
    logic                    tgt_frame;
    logic                    xfer;
    logic [4*NUM_DIGITS-1:0] tgt_act;
    logic [3:0]              tgt_nib;
`ifdef SEG_LZ_BLANK_EN
    logic                    upper_zero;
`endif

    // Everything needed to enter ON is resolved here, so the digit being
    // entered already sees the buffer that becomes active on this edge.
    always_comb begin
        go_on = 1'b0;
        unique case (state)
            S_OFF: go_on = 1'b1;
            S_ON:  go_on = (cnt == ON_LAST) && (DEAD_CYCLES == 0);
            S_GAP: go_on = (cnt == GAP_LAST);
            default: go_on = 1'b0;
        endcase

        if (state == S_OFF || idx == IDX_LAST) tgt_idx = '0;
        else                                   tgt_idx = idx + 1'b1;

        tgt_frame = (tgt_idx == '0);
        xfer      = en && go_on && tgt_frame && pending;
        tgt_act   = xfer ? pend_reg : act_reg;

        tgt_nib = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDXW'(i) == tgt_idx) tgt_nib = tgt_act[i*4 +: 4];
        end
`ifdef SEG_LZ_BLANK_EN
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDXW'(i) >= tgt_idx && tgt_act[i*4 +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (tgt_idx != '0 && upper_zero) tgt_nib = 4'hF;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            idx        <= '0;
            cnt        <= '0;
            pend_reg   <= '0;
            act_reg    <= '0;
            pending    <= 1'b0;
            digit_en   <= '0;
            bcd_out    <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;

            // A load coinciding with the transfer wins the pending flag,
            // while the transfer itself still takes the previous pend_reg.
            if (xfer) act_reg <= pend_reg;
            if (load) begin
                pend_reg <= bcd_in;
                pending  <= 1'b1;
            end else if (xfer) begin
                pending  <= 1'b0;
            end

            if (!en) begin
                state    <= S_OFF;
                idx      <= '0;
                cnt      <= '0;
                digit_en <= '0;
                bcd_out  <= 4'hF;
            end else if (go_on) begin
                state      <= S_ON;
                idx        <= tgt_idx;
                cnt        <= '0;
                digit_en   <= NUM_DIGITS'(1) << tgt_idx;
                bcd_out    <= tgt_nib;
                frame_tick <= tgt_frame;
            end else if (state == S_ON && cnt == ON_LAST) begin
                state    <= S_GAP;
                cnt      <= '0;
                digit_en <= '0;
                bcd_out  <= 4'hF;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: two controllers (dead time 1 and 0) sharing one stimulus.
module tb_seven_seg_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;

    logic [3:0] a_bcd, b_bcd, a_den, b_den;
    logic       a_pend, b_pend, a_ft, b_ft;

    seven_seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
        .bcd_out(a_bcd), .digit_en(a_den), .pending(a_pend), .frame_tick(a_ft)
    );

    seven_seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
        .bcd_out(b_bcd), .digit_en(b_den), .pending(b_pend), .frame_tick(b_ft)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dut;
        logic [15:0] tag;
        logic [3:0]  den;
        logic [3:0]  bcd;
        logic        ft;
        logic        pend;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   tag_cur = 0;

    function automatic logic [3:0] exp_nib(logic [15:0] v, int d);
        logic [3:0] n;
        n = 4'((v >> (4*d)) & 16'hF);
`ifdef SEG_LZ_BLANK_EN
        if (d > 0 && (v >> (4*d)) == 16'h0) n = 4'hF;
`endif
        return n;
    endfunction

    function automatic exp_t off_e(logic dut, logic pend);
        exp_t e;
        e.dut = dut; e.tag = '0; e.den = '0; e.bcd = 4'hF; e.ft = 1'b0; e.pend = pend;
        return e;
    endfunction

    // Dwell 4 + dead 1: 5-cycle slots, 20-cycle frame, k=0 is frame start.
    function automatic exp_t exp_a(int k, logic [15:0] act, logic pend);
        exp_t e;
        int p, d;
        p = k % 20; d = p / 5;
        e = off_e(1'b0, pend);
        e.ft = (p == 0);
        if ((p % 5) < 4) begin
            e.den = 4'(1 << d);
            e.bcd = exp_nib(act, d);
        end
        return e;
    endfunction

    // Dwell 4, no dead time: 16-cycle frame with digit always lit.
    function automatic exp_t exp_b(int k, logic [15:0] act, logic pend);
        exp_t e;
        int p, d;
        p = k % 16; d = p / 4;
        e = off_e(1'b1, pend);
        e.ft   = (p == 0);
        e.den  = 4'(1 << d);
        e.bcd  = exp_nib(act, d);
        return e;
    endfunction

    task automatic tick(input exp_t ea, input bit use_b, input exp_t eb);
        @(posedge clk);
        ea.tag = 16'(tag_cur);
        eb.tag = 16'(tag_cur);
        q.push_back(ea);
        if (use_b) q.push_back(eb);
        @(negedge clk);
    endtask

    // Monitor: compares every queued expectation against the sampled outputs.
    initial begin
        exp_t e;
        logic [9:0] got, want;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                e = q.pop_front();
                got  = e.dut ? {b_den, b_bcd, b_ft, b_pend} : {a_den, a_bcd, a_ft, a_pend};
                want = {e.den, e.bcd, e.ft, e.pend};
                total++;
                if (got === want) passed++;
                else $display("FAIL scan dut%0d tag%0d got den=%b bcd=%h ft=%b pend=%b exp den=%b bcd=%h ft=%b pend=%b",
                              e.dut, e.tag, got[9:6], got[5:2], got[1], got[0],
                              want[9:6], want[5:2], want[1], want[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] act, actb;
        logic        pend, pendb;

        @(negedge clk);
        tag_cur = 1;
        tick(off_e(0, 0), 1, off_e(1, 0));
        tick(off_e(0, 0), 1, off_e(1, 0));
        rst_n = 1'b1;
        tag_cur = 2;
        tick(off_e(0, 0), 1, off_e(1, 0));

        en = 1'b1;
        for (int k = 0; k <= 170; k++) begin
            tag_cur = 1000 + k;
            load = 1'b1;
            case (k)
                22:      bcd_in = 16'h1234;
                62:      bcd_in = 16'h0007;
                102:     bcd_in = 16'h1111;
                120:     bcd_in = 16'h2222;
                default: load = 1'b0;
            endcase
            if (k < 40)       begin act = 16'h0000; pend = (k >= 22);  end
            else if (k < 80)  begin act = 16'h1234; pend = (k >= 62);  end
            else if (k < 120) begin act = 16'h0007; pend = (k >= 102); end
            else if (k < 140) begin act = 16'h1111; pend = 1'b1;       end
            else              begin act = 16'h2222; pend = 1'b0;       end
            actb  = (k >= 32) ? 16'h1234 : 16'h0000;
            pendb = (k >= 22) && (k < 32);
            tick(exp_a(k, act, pend), (k < 40), exp_b(k, actb, pendb));
            load = 1'b0;
        end

        // Drop enable while digit 2 is lit.
        en = 1'b0;
        tag_cur = 3;
        tick(off_e(0, 0), 0, off_e(1, 0));
        tick(off_e(0, 0), 0, off_e(1, 0));

        en = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tag_cur = 2000 + k;
            load = (k == 5);
            bcd_in = 16'h3333;
            tick(exp_a(k, 16'h2222, (k >= 5)), 0, off_e(1, 0));
            load = 1'b0;
        end

        // Asynchronous reset asserted between edges, observed before the next edge.
        tag_cur = 4;
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.push_back(off_e(0, 0));
        q.push_back(off_e(1, 0));
        @(negedge clk);
        tick(off_e(0, 0), 1, off_e(1, 0));
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tag_cur = 3000 + k;
            tick(exp_a(k, 16'h0000, 1'b0), 1, exp_b(k, 16'h0000, 1'b0));
        end

        @(negedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain got %0d entries left exp 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_controller.md
# seven_seg_scan_controller

Time-multiplexed scan controller that shares the team's single combinational BCD-to-7-segment decoder across `NUM_DIGITS` common-anode/cathode digit positions. It drives the shared decoder's 4-bit BCD input and a one-hot digit enable, cycling through the digits with a programmable dwell time and anti-ghosting dead time. New display values are double-buffered so a frame never shows a mix of old and new digits. It sits between the system logic producing packed BCD values and the decoder/pad drivers.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `REFRESH_DIV`, 50000: clock cycles each digit is enabled (>=1).
- `DEAD_CYCLES`, 2: clock cycles with all digits off between digits (0 = no gap).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: scan enable; low forces display off.
- `load` input 1: one-cycle strobe capturing `bcd_in`.
- `bcd_in` input 4*NUM_DIGITS: packed BCD, digit 0 (rightmost, least significant) in [3:0].
- `bcd_out` output 4: BCD code to the shared decoder; 4'hF = blank (decoder blanks invalid codes).
- `digit_en` output NUM_DIGITS: one-hot active-high digit enable; bit i selects digit i.
- `pending` output 1: captured value waiting for next frame start.
- `frame_tick` output 1: one-cycle pulse at each frame start.

## Operation
- Registers: `pend_reg` and `act_reg` (4*NUM_DIGITS each), digit index, dwell counter, state.
- States: OFF (all digits off), ON (digit_en one-hot for current index), GAP (all digits off).
- OFF -> ON(digit 0) when `en`=1. ON -> GAP after REFRESH_DIV cycles; if DEAD_CYCLES=0, ON -> ON(next digit) directly. GAP -> ON(next digit) after DEAD_CYCLES cycles. Index wraps NUM_DIGITS-1 -> 0.
- Any state -> OFF when `en`=0 (takes effect next edge); index and counter reset to 0.
- Frame start = every entry to ON with index 0 (from OFF, GAP or ON). At frame start: if `pending`=1, `act_reg` <= `pend_reg`, `pending` <= 0; `frame_tick`=1 for that cycle.
- `load`=1: `pend_reg` <= `bcd_in`, `pending` <= 1 on same edge. Load coincident with frame start: transfer uses the old `pend_reg`; new value captured, `pending` stays 1.
- In ON, `bcd_out` = `act_reg` nibble of current index (after blanking); in OFF/GAP, `bcd_out` = 4'hF.
- Codes 4'hA–4'hF in `act_reg` pass through unchanged (decoder blanks them).

## Timing
- Reset values: `digit_en`=0, `bcd_out`=4'hF, `pending`=0, `frame_tick`=0, `act_reg`=`pend_reg`=0, index 0, state OFF.
- All outputs registered; `digit_en`, `bcd_out`, `frame_tick` change on the same edge as the state transition.
- First digit enabled 1 cycle after `en` seen high; frame period = NUM_DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
- `pending` rises the edge `load` is sampled; clears at next frame start.
- Reset mid-frame: all outputs return to reset values asynchronously; scan restarts from OFF.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking — any digit i>0 whose nibble and all higher nibbles in `act_reg` are 0 outputs 4'hF in ON; digit 0 always displayed.
- Not defined: every digit's nibble displayed as stored.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1; reset, `en`=1 -> `digit_en` 0001,0000,0010,0000,0100,0000,1000,0000 with 4/1-cycle dwell, `frame_tick` every 20 cycles.
- `load` with `bcd_in`=16'h1234 mid-frame -> `pending`=1 until next frame start; then `bcd_out` 4,3,2,1 for digits 0..3, `pending`=0.
- `load` 16'h0007 with `SEG_LZ_BLANK_EN` -> digits 1..3 `bcd_out`=4'hF, digit 0 = 7; without macro -> 0,0,0 shown.
- `load` coincident with frame start (old pend 16'h1111, new 16'h2222) -> frame shows 1111, `pending` stays 1, next frame shows 2222.
- DEAD_CYCLES=0 -> no all-off cycles; `digit_en` advances every 4 cycles.
- `en` dropped during digit 2, then `rst_n` pulsed low mid-frame -> `digit_en`=0, `bcd_out`=4'hF next edge / immediately; restart begins at digit 0.
